// File: rtl/spi_reg_bridge_pkg.sv
// Shared constants for the SPI-to-register bridge: parameter defaults, FSM
// encodings and command-byte field positions.
package spi_reg_bridge_pkg;

    localparam int DEF_ADDR_W      = 6;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_LSB = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CMD  = 2'd1;
    localparam state_t ST_DATA = 2'd2;

    // Bit 6 of the command byte is reserved and deliberately not decoded.
    function automatic logic cmd_is_write(input logic [7:0] cmd);
        return cmd[CMD_RW_BIT];
    endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Single-cycle register-file bus: the bridge is the master issuing strobes,
// the register file is the slave returning combinational read data.
interface spi_reg_bridge_if
    import spi_reg_bridge_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;

    modport master (
        output read,
        output write,
        output addr,
        output data_write,
        input  data_read
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  data_write,
        output data_read
    );

endinterface

// File: rtl/spi_reg_bridge_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with single-cycle rise and
// fall pulses derived from the synchronized level and its previous value.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Next-state of the synchronizer chain and the edge-history flop.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // Chain flops; reset low so a pin already low at release makes no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that converts command/data bytes into single-cycle read and
// write strobes on the register bus, with address auto-increment for bursts.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    spi_reg_bridge_if.master bus
);

    localparam int CNT_W = $clog2(DATA_W);

    logic sclk_rise_s;
    logic sclk_fall_s;
    logic cs_sync_s;
    logic cs_fall_s;
    logic unused_sclk_lvl_s;
    logic unused_cs_rise_s;
    logic unused_s;

    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_d;

    state_t            state_q,      state_d;
    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0] rx_shreg_q,   rx_shreg_d;
    logic [DATA_W-1:0] tx_shreg_q,   tx_shreg_d;
    logic              rw_q,         rw_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] data_write_q, data_write_d;
    logic              byte_done_q,  byte_done_d;
    logic              read_q,       read_d;
    logic              write_q,      write_d;
    logic              miso_q,       miso_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .dout  (unused_sclk_lvl_s),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs_n),
        .dout  (cs_sync_s),
        .rise  (unused_cs_rise_s),
        .fall  (cs_fall_s)
    );

    assign unused_s = unused_sclk_lvl_s ^ unused_cs_rise_s;

    // MOSI only needs the level; it is sampled on the synced sclk rise pulse.
    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    // Transaction FSM, shift registers and bus-strobe generation.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shreg_d   = rx_shreg_q;
        tx_shreg_d   = tx_shreg_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        byte_done_d  = 1'b0;
        read_d       = 1'b0;
        write_d      = 1'b0;

        // A write strobe is followed by the burst address advance.
        if (write_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end else begin
            addr_d = addr_q;
        end

        if (cs_sync_s) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            rx_shreg_d = '0;
            tx_shreg_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_d    = ST_CMD;
                        bit_cnt_d  = '0;
                        rx_shreg_d = '0;
                        tx_shreg_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD, ST_DATA: begin
                    // Read data is loaded in the strobe cycle; the fall that
                    // closes a byte (bit_cnt back at 0) must not shift it out.
                    if (read_q && (state_q == ST_DATA) && !rw_q) begin
                        tx_shreg_d = bus.data_read;
                    end else if (sclk_fall_s && (bit_cnt_q != CNT_W'(0))) begin
                        tx_shreg_d = {tx_shreg_q[DATA_W-2:0], 1'b0};
                    end else begin
                        tx_shreg_d = tx_shreg_q;
                    end

                    if (sclk_rise_s) begin
                        rx_shreg_d  = {rx_shreg_q[DATA_W-2:0], mosi_sync_q[SYNC_STAGES-1]};
                        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                        byte_done_d = (bit_cnt_q == CNT_W'(DATA_W - 1));
                    end else begin
                        byte_done_d = 1'b0;
                    end

                    if (byte_done_q) begin
                        if (state_q == ST_CMD) begin
                            rw_d    = cmd_is_write(rx_shreg_q);
                            addr_d  = rx_shreg_q[CMD_ADDR_LSB +: ADDR_W];
                            state_d = ST_DATA;
                            read_d  = !cmd_is_write(rx_shreg_q);
                        end else if (rw_q) begin
                            write_d      = 1'b1;
                            data_write_d = rx_shreg_q;
                        end else begin
                            // Prefetch the next burst byte before its first bit is due.
                            addr_d = addr_q + ADDR_W'(1);
                            read_d = 1'b1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end

        if ((state_d == ST_DATA) && !rw_d) begin
            miso_d = tx_shreg_d[DATA_W-1];
        end else begin
            miso_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q  <= '0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rx_shreg_q   <= '0;
            tx_shreg_q   <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            data_write_q <= '0;
            byte_done_q  <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            miso_q       <= 1'b0;
        end else begin
            mosi_sync_q  <= mosi_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shreg_q   <= rx_shreg_d;
            tx_shreg_q   <= tx_shreg_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            byte_done_q  <= byte_done_d;
            read_q       <= read_d;
            write_q      <= write_d;
            miso_q       <= miso_d;
        end
    end

    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.addr       = addr_q;
    assign bus.data_write = data_write_q;
    assign miso           = miso_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: a table of SPI transactions with
// hand-computed strobe logs and MISO bytes, plus abort/reset sequences.
module tb_spi_reg_bridge;

    logic clk;
    logic rst_n;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic rd_mode;

    int total;
    int bad;
    int both_cnt;

    spi_reg_bridge_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    spi_reg_bridge #(.ADDR_W(6), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .cs_n  (cs_n),
        .mosi  (mosi),
        .miso  (miso),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: mode 0 holds 0x3C at 0x0D, mode 1 returns addr^0xFF.
    always_comb begin
        if (rd_mode) bus.data_read = 8'hFF ^ {2'b00, bus.addr};
        else         bus.data_read = (bus.addr == 6'h0D) ? 8'h3C : 8'h00;
    end

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wev_t;

    wev_t       wr_log[$];
    logic [5:0] rd_log[$];

    always @(negedge clk) begin
        if (bus.write) wr_log.push_back('{a: bus.addr, d: bus.data_write});
        if (bus.read)  rd_log.push_back(bus.addr);
        if (bus.read && bus.write) both_cnt++;
    end

    // Transaction record; packed arrays are indexed [byte/event number].
    typedef struct packed {
        logic [7:0]      nb;
        logic [2:0][7:0] tx;
        logic            mode;
        logic [7:0]      nwr;
        logic [1:0][5:0] wa;
        logic [1:0][7:0] wd;
        logic [7:0]      nrd;
        logic [2:0][5:0] ra;
        logic [1:0][7:0] rx;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic half_bit();
        repeat (8) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            half_bit();
            rx[7-i] = miso;
            sclk = 1'b1;
            half_bit();
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (16) @(negedge clk);
        cs_n = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic [7:0] rx;
        wr_log.delete();
        rd_log.delete();
        rd_mode = v.mode;
        cs_low();
        for (int k = 0; k < int'(v.nb); k++) begin
            send_bits(v.tx[k], 8, rx);
            if (k >= 1) chk($sformatf("%s miso byte%0d", nm, k), {24'h0, rx}, {24'h0, v.rx[k-1]});
        end
        cs_high();
        chk($sformatf("%s miso idle", nm), {31'h0, miso}, 32'h0);
        chk($sformatf("%s write count", nm), wr_log.size(), {24'h0, v.nwr});
        for (int i = 0; i < int'(v.nwr); i++) begin
            chk($sformatf("%s write%0d", nm, i),
                (i < wr_log.size()) ? {18'h0, wr_log[i]} : 32'hDEAD_BEEF,
                {18'h0, v.wa[i], v.wd[i]});
        end
        chk($sformatf("%s read count", nm), rd_log.size(), {24'h0, v.nrd});
        for (int i = 0; i < int'(v.nrd); i++) begin
            chk($sformatf("%s read%0d addr", nm, i),
                (i < rd_log.size()) ? {26'h0, rd_log[i]} : 32'hDEAD_BEEF,
                {26'h0, v.ra[i]});
        end
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, " read"},       {31'h0, bus.read},       32'h0);
        chk({nm, " write"},      {31'h0, bus.write},      32'h0);
        chk({nm, " addr"},       {26'h0, bus.addr},       32'h0);
        chk({nm, " data_write"}, {24'h0, bus.data_write}, 32'h0);
        chk({nm, " miso"},       {31'h0, miso},           32'h0);
    endtask

    initial begin
        logic [7:0] rx;
        vec_t v;
        total = 0; bad = 0; both_cnt = 0;
        rst_n = 1'b0; cs_n = 1'b0; sclk = 1'b0; mosi = 1'b0; rd_mode = 1'b0;

        vecs[0] = '{nb: 8'd2, tx: {8'h00, 8'h05, 8'h8A}, mode: 1'b0,
                    nwr: 8'd1, wa: {6'h00, 6'h0A}, wd: {8'h00, 8'h05},
                    nrd: 8'd0, ra: {6'h00, 6'h00, 6'h00}, rx: {8'h00, 8'h00}};
        vecs[1] = '{nb: 8'd2, tx: {8'h00, 8'h00, 8'h0D}, mode: 1'b0,
                    nwr: 8'd0, wa: {6'h00, 6'h00}, wd: {8'h00, 8'h00},
                    nrd: 8'd2, ra: {6'h00, 6'h0E, 6'h0D}, rx: {8'h00, 8'h3C}};
        vecs[2] = '{nb: 8'd3, tx: {8'h12, 8'h34, 8'h80}, mode: 1'b0,
                    nwr: 8'd2, wa: {6'h01, 6'h00}, wd: {8'h12, 8'h34},
                    nrd: 8'd0, ra: {6'h00, 6'h00, 6'h00}, rx: {8'h00, 8'h00}};
        vecs[3] = '{nb: 8'd3, tx: {8'h00, 8'h00, 8'h3F}, mode: 1'b1,
                    nwr: 8'd0, wa: {6'h00, 6'h00}, wd: {8'h00, 8'h00},
                    nrd: 8'd3, ra: {6'h01, 6'h00, 6'h3F}, rx: {8'hFF, 8'hC0}};
        vecs[4] = '{nb: 8'd2, tx: {8'h00, 8'h55, 8'hC7}, mode: 1'b0,
                    nwr: 8'd1, wa: {6'h00, 6'h07}, wd: {8'h00, 8'h55},
                    nrd: 8'd0, ra: {6'h00, 6'h00, 6'h00}, rx: {8'h00, 8'h00}};
        vecs[5] = '{nb: 8'd2, tx: {8'h00, 8'h00, 8'h4D}, mode: 1'b1,
                    nwr: 8'd0, wa: {6'h00, 6'h00}, wd: {8'h00, 8'h00},
                    nrd: 8'd2, ra: {6'h00, 6'h0E, 6'h0D}, rx: {8'h00, 8'hF2}};

        repeat (5) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_outputs_zero("post-reset");

        // cs_n already low at release: bytes clocked without a falling edge.
        wr_log.delete(); rd_log.delete();
        send_bits(8'h81, 8, rx);
        send_bits(8'h11, 8, rx);
        cs_high();
        chk("held-cs write count", wr_log.size(), 32'd0);
        chk("held-cs read count",  rd_log.size(), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort mid data byte, then a complete write to the same address.
        wr_log.delete(); rd_log.delete();
        cs_low();
        send_bits(8'h85, 8, rx);
        send_bits(8'hF0, 4, rx);
        cs_high();
        chk("abort write count", wr_log.size(), 32'd0);
        chk("abort miso", {31'h0, miso}, 32'h0);
        v = vecs[0];
        v.tx = {8'h00, 8'hAA, 8'h85}; v.wa = {6'h00, 6'h05}; v.wd = {8'h00, 8'hAA};
        run_vec(v, "after-abort");

        // Reset in the middle of the data byte of a write.
        wr_log.delete(); rd_log.delete();
        cs_low();
        send_bits(8'h8A, 8, rx);
        send_bits(8'h5A, 4, rx);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("mid-reset");
        rst_n = 1'b1;
        send_bits(8'hA5, 4, rx);
        cs_high();
        chk("mid-reset write count", wr_log.size(), 32'd0);
        chk("mid-reset read count",  rd_log.size(), 32'd0);
        run_vec(vecs[0], "after-reset");

        chk("read/write overlap", both_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
SPI slave (mode 0, MSB first) that turns serial transactions into the single-cycle read/write/addr/data bus used by the peripheral register file. It initiates on that bus: it issues the strobes and captures read data for return on MISO. It sits between the chip pins and the register block, all in the clk domain, with SPI inputs oversampled.

Parameters:
ADDR_W, 6, register address width
DATA_W, 8, register data width (one SPI byte)
SYNC_STAGES, 2, synchronizer flops on sclk/cs_n/mosi

Ports:
clk  input  1  peripheral clock
rst_n  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from master; sclk ≤ clk/8
cs_n  input  1  SPI chip select, active low
mosi  input  1  SPI data in
miso  output  1  SPI data out
read  output  1  one-cycle read strobe to register file
write  output  1  one-cycle write strobe to register file
addr  output  ADDR_W  register address, stable between strobes
data_write  output  DATA_W  write data, valid with write
data_read  input  DATA_W  combinational read data, sampled in the read cycle

Behaviour:
- Reset: read=0, write=0, addr=0, data_write=0, miso=0, state=IDLE, bit_cnt=0, shift registers=0.
- sclk, cs_n and mosi each pass through SYNC_STAGES flops. Rise/fall pulses come from the synced sclk versus its previous value.
- State IDLE: miso=0. A synced cs_n falling edge goes to CMD with bit_cnt=0.
- A synced cs_n high in any state goes to IDLE on the next clk. A partial byte is discarded, no strobe is issued, and miso returns to 0.
- On each sclk rise in CMD or DATA: rx_shreg <= {rx_shreg[6:0], mosi}; bit_cnt++ (3-bit).
- Byte completes when bit_cnt reaches 8 (wraps to 0). The byte is acted on in the following clk.
- CMD byte complete:
  - rw <= bit7 (1=write, 0=read); addr <= bits5:0; bit6 reserved, ignored.
  - Go to DATA.
  - If read: pulse read for 1 clk and load tx_shreg <= data_read in that same cycle.
- DATA byte complete, write: pulse write for 1 clk with data_write=byte at the current addr. addr <= addr+1 in the next cycle.
- DATA byte complete, read: addr <= addr+1, then pulse read for the new addr and reload tx_shreg. This prefetches the next byte of the burst.
- Bursts stay in DATA until cs_n rises. addr wraps modulo 2^ADDR_W (0x3F→0x00).
- MISO: miso = tx_shreg[7] while in DATA with rw=0, else 0.
  - tx_shreg shifts left on sclk fall only when bit_cnt≠0.
  - So the falling edge that ends the command byte does not shift, and bit7 is valid before the first data rising edge.
  - The sclk ≤ clk/8 rule guarantees the load happens before that edge.
- read and write are never high in the same cycle. Each strobe is exactly 1 clk per completed byte.
- Reads have no side effects, so the trailing prefetch read in a burst is harmless.
- Reset mid-transaction: everything returns to reset values immediately. No strobe is issued until a new cs_n falling edge is seen after release.
- cs_n held low at reset release does not start a transaction. A falling edge is required.

Decomposition:
- Shared package:
  - state enum {IDLE, CMD, DATA}
  - CMD_RW_BIT=7
  - CMD_ADDR_LSB=0
  - ADDR_W/DATA_W defaults
- Sub-module spi_sync_edge: SYNC_STAGES-flop synchronizer plus rise/fall pulse outputs. Instantiated for sclk and cs_n; mosi uses the synchronizer only.

Test Plan:
1. Single write: cs_n low, bytes 0x8A, 0x05 → exactly one write pulse, addr=0x0A, data_write=0x05; read never asserted.
2. Single read: model returns 0x3C at 0x0D; bytes 0x0D, 0x00 → read pulse with addr=0x0D; MISO carries 0x3C during byte 2; miso=0 after cs_n high.
3. Burst write: bytes 0x80, 0x34, 0x12 → writes (addr 0x00, 0x34) then (addr 0x01, 0x12).
4. Burst read with wrap: model returns addr^0xFF; bytes 0x3F, 0x00, 0x00 → MISO 0xC0 then 0xFF; read pulses at addr 0x3F, 0x00, 0x01.
5. Abort: 0x85 then 4 data bits, cs_n high → no write, state IDLE. A following full write 0x85, 0xAA → a single write of 0xAA at 0x05.
6. Reset mid-byte: rst_n low during byte 2 of a write → all outputs 0, no write pulse. After release, a normal transaction succeeds.
